// File: rtl/rank_filter.sv
// Rank-order filter: collects a window of N unsigned samples, then returns the sample
// at the requested descending rank after a fixed N-cycle scan.
module rank_filter #(
    parameter int WIDTH = 8,
    parameter int N     = 9
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 DSI,
    input  logic [WIDTH-1:0]     DI,
    input  logic [$clog2(N)-1:0] RANK,
    output logic [WIDTH-1:0]     DO,
    output logic                 DSO,
    output logic                 BUSY
);

    localparam int RW = $clog2(N);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     rank_q, rank_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              found_q, found_d;
    logic [WIDTH-1:0]  do_q, do_d;
    logic              dso_q, dso_d;

    logic [WIDTH-1:0]  slot_q [N];
    logic              cap_en;
    logic [RW-1:0]     cap_idx;
    logic [CW-1:0]     rank_in;
    logic [WIDTH-1:0]  cand;
    logic [CW-1:0]     g_cnt, e_cnt;
    logic              match;

    assign rank_in = CW'(RANK);
    assign cap_en  = DSI && (state_q == IDLE || state_q == LOAD);
    assign cap_idx = (state_q == IDLE) ? '0 : count_q[RW-1:0];
    assign cand    = slot_q[idx_q[RW-1:0]];

    // NOTE: the sample window is plain storage with no reset; the FSM never reads a slot before writing it.
    always_ff @(posedge CLK) begin
        if (cap_en) slot_q[cap_idx] <= DI;
    end

    // Candidate matches when the requested rank falls inside the run of ranks its value occupies.
    always_comb begin
        g_cnt = '0;
        e_cnt = '0;
        for (int k = 0; k < N; k++) begin
            if (slot_q[k] > cand)       g_cnt = g_cnt + ONE;
            else if (slot_q[k] == cand) e_cnt = e_cnt + ONE;
        end
        match = (rank_q >= g_cnt) && (rank_q < g_cnt + e_cnt);
    end

    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        rank_d  = rank_q;
        res_d   = res_q;
        found_d = found_q;
        do_d    = do_q;
        dso_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (DSI) begin
                    rank_d  = (rank_in > LAST) ? LAST : rank_in;
                    count_d = ONE;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (DSI) begin
                    count_d = count_q + ONE;
                    if (count_q == LAST) begin
                        state_d = SCAN;
                        idx_d   = '0;
                        found_d = 1'b0;
                    end
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (match && !found_q) begin
                    res_d   = cand;
                    found_d = 1'b1;
                end
                idx_d = idx_q + ONE;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                do_d    = res_q;
                dso_d   = 1'b1;
                count_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            rank_q  <= '0;
            res_q   <= '0;
            found_q <= 1'b0;
            do_q    <= '0;
            dso_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            rank_q  <= rank_d;
            res_q   <= res_d;
            found_q <= found_d;
            do_q    <= do_d;
            dso_q   <= dso_d;
        end
    end

    assign DO   = do_q;
    assign DSO  = dso_q;
    assign BUSY = (state_q == SCAN) || (state_q == DONE);

endmodule

// File: tb/tb_rank_filter.sv
// Scoreboard bench for rank_filter: drivers queue expected results, a monitor
// pops and compares them on every DSO pulse and checks DO holds otherwise.
module tb_rank_filter;

    localparam int WIDTH = 8;
    localparam int N     = 9;
    localparam int RW    = $clog2(N);

    logic             CLK = 1'b0;
    logic             RST;
    logic             DSI;
    logic [WIDTH-1:0] DI;
    logic [RW-1:0]    RANK;
    logic [WIDTH-1:0] DO;
    logic             DSO;
    logic             BUSY;

    int tests   = 0;
    int fails   = 0;
    int dso_cnt = 0;
    logic [WIDTH-1:0] exp_q [$];

    always #5 CLK = ~CLK;

    rank_filter #(.WIDTH(WIDTH), .N(N)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .DSI  (DSI),
        .DI   (DI),
        .RANK (RANK),
        .DO   (DO),
        .DSO  (DSO),
        .BUSY (BUSY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_pick(input logic [WIDTH-1:0] s [N], input int r);
        logic [WIDTH-1:0] t [N];
        logic [WIDTH-1:0] tmp;
        int rr;
        t = s;
        for (int a = 0; a < N - 1; a++)
            for (int b = 0; b < N - 1 - a; b++)
                if (t[b] < t[b+1]) begin
                    tmp = t[b]; t[b] = t[b+1]; t[b+1] = tmp;
                end
        rr = (r > N - 1) ? N - 1 : r;
        return t[rr];
    endfunction

    // Sample one time unit after each rising edge.
    initial begin : monitor
        logic [WIDTH-1:0] prev_do;
        logic [WIDTH-1:0] e;
        prev_do = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (RST !== 1'b1) begin
                if (DSO) begin
                    dso_cnt++;
                    check("dso_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("do_result", DO, e);
                    end
                end else begin
                    check("do_hold", DO, prev_do);
                end
            end
            prev_do = DO;
        end
    end

    task automatic tick_idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            DSI  = 1'b0;
            DI   = WIDTH'($urandom);
            RANK = RW'($urandom);
        end
    endtask

    // Holds DSI high with junk while BUSY, then gap idle cycles, then len samples.
    task automatic send_frame(input logic [WIDTH-1:0] s [N], input int rank, input int gap,
                              input int len, input bit push, input logic [WIDTH-1:0] exp);
        int guard;
        guard = 0;
        @(negedge CLK);
        while (BUSY && guard < 50) begin
            DSI  = 1'b1;
            DI   = WIDTH'($urandom);
            RANK = RW'($urandom);
            guard++;
            @(negedge CLK);
        end
        if (guard >= 50) check("busy_timeout", guard, 0);
        for (int g = 0; g < gap; g++) begin
            DSI  = 1'b0;
            DI   = WIDTH'($urandom);
            @(negedge CLK);
        end
        for (int k = 0; k < len; k++) begin
            DSI  = 1'b1;
            DI   = s[k];
            RANK = (k == 0) ? RW'(rank) : RW'($urandom);
            if (k < len - 1) @(negedge CLK);
        end
        if (push) exp_q.push_back(exp);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d results pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [WIDTH-1:0] f [N];
        int lat;
        int cnt_before;
        int rk;
        int guard;

        RST = 1'b1; DSI = 1'b0; DI = '0; RANK = '0;
        @(posedge CLK); #1;
        check("rst_do", DO, 0);
        check("rst_dso", DSO, 0);
        check("rst_busy", BUSY, 0);
        @(negedge CLK); RST = 1'b0;

        // Median of 1..9 in scrambled order, plus fixed latency to DSO.
        f = '{8'd3, 8'd9, 8'd1, 8'd7, 8'd5, 8'd2, 8'd8, 8'd6, 8'd4};
        send_frame(f, 4, 1, N, 1'b1, 8'd5);
        @(posedge CLK);
        lat = 0;
        while (lat < 40) begin
            @(posedge CLK); #1;
            lat++;
            if (DSO) break;
        end
        check("latency", lat, N + 1);

        f = '{8'd200, 8'd17, 8'd255, 8'd0, 8'd99, 8'd1, 8'd254, 8'd3, 8'd128};
        send_frame(f, 0, 0, N, 1'b1, 8'd255);
        send_frame(f, 8, 2, N, 1'b1, 8'd0);

        f = '{default: 8'd7};
        send_frame(f, 4, 0, N, 1'b1, 8'd7);
        f = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        send_frame(f, 3, 1, N, 1'b1, 8'd5);
        send_frame(f, 4, 3, N, 1'b1, 8'd1);

        // Aborted frame: no result, DO keeps the previous value.
        f = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        send_frame(f, 4, 0, 5, 1'b0, 8'd0);
        cnt_before = dso_cnt;
        tick_idle(15);
        check("abort_do", DO, 1);
        check("abort_no_dso", dso_cnt, cnt_before);
        f = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send_frame(f, 4, 0, N, 1'b1, 8'd5);

        // Reset in the third scan cycle kills the frame.
        f = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88, 8'd99};
        send_frame(f, 4, 0, N, 1'b0, 8'd0);
        cnt_before = dso_cnt;
        @(negedge CLK); DSI = 1'b0;
        @(negedge CLK);
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1;
        check("midscan_rst_do", DO, 0);
        check("midscan_rst_dso", DSO, 0);
        check("midscan_rst_busy", BUSY, 0);
        @(negedge CLK); RST = 1'b0;
        tick_idle(20);
        check("midscan_rst_no_dso", dso_cnt, cnt_before);

        // Out-of-range rank clamps to the smallest sample.
        f = '{8'd40, 8'd12, 8'd77, 8'd90, 8'd33, 8'd25, 8'd61, 8'd18, 8'd50};
        send_frame(f, 15, 1, N, 1'b1, 8'd12);

        for (int fr = 0; fr < 1000; fr++) begin
            for (int k = 0; k < N; k++) f[k] = WIDTH'($urandom);
            if (fr % 7 == 0) f[$urandom_range(0, N - 1)] = f[0];
            rk = $urandom_range(0, (1 << RW) - 1);
            send_frame(f, rk, $urandom_range(0, 3), N, 1'b1, ref_pick(f, rk));
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            @(negedge CLK);
            DSI = 1'b0;
            guard++;
        end
        tick_idle(3);
        check("drain_pending", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
